// File: rtl/flash_seq.sv
// flash_seq: write-then-verify sequencer for a byte-wide flash controller.
// A run writes LEN bytes starting at ADDR_BASE with data (addr ^ SEED), reads
// them back, compares against the same pattern and reports pass/fail, the
// number of mismatching bytes and the first mismatching address.
// Build option: define FLASH_SEQ_TIMEOUT_EN to abort a run when the controller
// leaves a request unanswered for TIMEOUT cycles; without it the sequencer waits
// on done indefinitely and timeout is tied low.

module flash_seq #(
    parameter logic [7:0] ADDR_BASE = 8'h00,
    parameter int         LEN       = 16,
    parameter logic [7:0] SEED      = 8'hA5,
    parameter int         TIMEOUT   = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [7:0] addr,
    output logic [7:0] data_wr,
    input  logic [7:0] data_rd,
    output logic       direction_rw,
    output logic       do_rw,
    input  logic       done,
    output logic       busy,
    output logic       pass,
    output logic       fail,
    output logic       timeout,
    output logic [7:0] err_count,
    output logic [7:0] fail_addr
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        READ   = 2'd2,
        FINISH = 2'd3
    } state_t;

    // Index of the final byte of a run; LEN=256 maps to 8'hFF.
    localparam logic [7:0] LAST_INDEX = 8'(LEN - 1);

    state_t     state_q, state_d;
    logic [7:0] index_q, index_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] data_wr_q, data_wr_d;
    logic       direction_rw_q, direction_rw_d;
    logic       do_rw_q, do_rw_d;
    logic       busy_q, busy_d;
    logic       pass_q, pass_d;
    logic       fail_q, fail_d;
    logic [7:0] err_count_q, err_count_d;
    logic [7:0] fail_addr_q, fail_addr_d;

    logic       run_start;
    logic       tmo_hit;
    logic       mismatch;
    logic       last_index;
    logic       clean_so_far;
    logic [7:0] tgt_addr;

    // start only counts while no run is in progress.
    assign run_start    = start && (state_q == IDLE || state_q == FINISH);
    // Address arithmetic is 8-bit, so runs crossing 8'hFF wrap to 8'h00.
    assign tgt_addr     = ADDR_BASE + index_q;
    // addr_q still holds the address of the outstanding read in the done cycle.
    assign mismatch     = data_rd != (addr_q ^ SEED);
    assign last_index   = index_q == LAST_INDEX;
    assign clean_so_far = (err_count_q == 8'd0) && !mismatch;

`ifdef FLASH_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] tmo_cnt_q;
    logic          timeout_q;

    // Timeout fires on the TIMEOUT-th cycle of an unanswered request.
    assign tmo_hit = do_rw_q && !done && (tmo_cnt_q == TW'(TIMEOUT - 1));

    // Count cycles the current request has been outstanding.
    always_ff @(posedge clk) begin
        if (rst || !do_rw_q || done) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
    end

    // Timeout flag: set on expiry, cleared by a new run or reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_q <= 1'b0;
        end else if (run_start) begin
            timeout_q <= 1'b0;
        end else if (tmo_hit) begin
            timeout_q <= 1'b1;
        end
    end

    assign timeout = timeout_q;
`else
    assign tmo_hit = 1'b0;
    assign timeout = 1'b0;
`endif

    // Next-state and next-output logic for the sequencer.
    always_comb begin
        // NOTE: every target gets a default before any branch so no path leaves
        // it unassigned; a missing default here would infer a latch.
        state_d        = state_q;
        index_d        = index_q;
        addr_d         = addr_q;
        data_wr_d      = data_wr_q;
        direction_rw_d = direction_rw_q;
        do_rw_d        = do_rw_q;
        busy_d         = busy_q;
        pass_d         = pass_q;
        fail_d         = fail_q;
        err_count_d    = err_count_q;
        fail_addr_d    = fail_addr_q;

        case (state_q)
            IDLE, FINISH: begin
                if (run_start) begin
                    state_d     = WRITE;
                    index_d     = 8'd0;
                    busy_d      = 1'b1;
                    pass_d      = 1'b0;
                    fail_d      = 1'b0;
                    err_count_d = 8'd0;
                    fail_addr_d = 8'd0;
                end
            end

            WRITE, READ: begin
                if (tmo_hit) begin
                    // Controller never answered: abandon the run as failed.
                    state_d = FINISH;
                    do_rw_d = 1'b0;
                    busy_d  = 1'b0;
                    pass_d  = 1'b0;
                    fail_d  = 1'b1;
                end else if (!do_rw_q) begin
                    // Gap cycle between requests: present the next one.
                    do_rw_d        = 1'b1;
                    addr_d         = tgt_addr;
                    data_wr_d      = tgt_addr ^ SEED;
                    direction_rw_d = (state_q == READ);
                end else if (done) begin
                    do_rw_d = 1'b0;
                    if (state_q == READ && mismatch) begin
                        if (err_count_q != 8'hFF) begin
                            err_count_d = err_count_q + 8'd1;
                        end
                        if (err_count_q == 8'd0) begin
                            fail_addr_d = addr_q;
                        end
                    end
                    if (!last_index) begin
                        index_d = index_q + 8'd1;
                    end else if (state_q == WRITE) begin
                        state_d = READ;
                        index_d = 8'd0;
                    end else begin
                        state_d = FINISH;
                        busy_d  = 1'b0;
                        pass_d  = clean_so_far;
                        fail_d  = !clean_so_far;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset wins over any pending start or done.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples its pre-edge value, independent of statement order.
        if (rst) begin
            state_q        <= IDLE;
            index_q        <= 8'd0;
            addr_q         <= 8'd0;
            data_wr_q      <= 8'd0;
            direction_rw_q <= 1'b0;
            do_rw_q        <= 1'b0;
            busy_q         <= 1'b0;
            pass_q         <= 1'b0;
            fail_q         <= 1'b0;
            err_count_q    <= 8'd0;
            fail_addr_q    <= 8'd0;
        end else begin
            state_q        <= state_d;
            index_q        <= index_d;
            addr_q         <= addr_d;
            data_wr_q      <= data_wr_d;
            direction_rw_q <= direction_rw_d;
            do_rw_q        <= do_rw_d;
            busy_q         <= busy_d;
            pass_q         <= pass_d;
            fail_q         <= fail_d;
            err_count_q    <= err_count_d;
            fail_addr_q    <= fail_addr_d;
        end
    end

    assign addr         = addr_q;
    assign data_wr      = data_wr_q;
    assign direction_rw = direction_rw_q;
    assign do_rw        = do_rw_q;
    assign busy         = busy_q;
    assign pass         = pass_q;
    assign fail         = fail_q;
    assign err_count    = err_count_q;
    assign fail_addr    = fail_addr_q;

endmodule
